// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: register-file port and CPU irq/ack handshake of the interrupt controller.
interface interrupt_controller_if #(
    parameter int word_size        = 32,
    parameter int reg_address_size = 5
);
    logic [reg_address_size-1:0] ir_address;
    logic [word_size-1:0]        ir_data_in;
    logic [word_size-1:0]        ir_rdata;
    logic                        ir_load;
    logic                        ir_store;
    logic                        cpu_irq;
    logic [word_size-1:0]        cpu_vector;
    logic [7:0]                  cpu_source;
    logic                        cpu_ack;

    modport master (
        output ir_address, ir_data_in, ir_load, ir_store, cpu_irq, cpu_vector, cpu_source,
        input  ir_rdata, cpu_ack
    );
    modport slave (
        input  ir_address, ir_data_in, ir_load, ir_store, cpu_irq, cpu_vector, cpu_source,
        output ir_rdata, cpu_ack
    );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-captured, fixed-priority interrupt sequencer that fetches the
// handler vector, logs a cause word to the register file and raises cpu_irq until acked.
module interrupt_controller #(
    parameter int word_size        = 32,
    parameter int reg_address_size = 5,
    parameter int num_sources      = 4,
    parameter int cause_address    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [num_sources-1:0] irq_req,
    input  logic [num_sources-1:0] irq_mask,
    output logic                   busy,
    interrupt_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, LOG, REQUEST} state_t;

    state_t                 state, state_nx;
    logic [num_sources-1:0] pending, req_prev, rise, eligible, ack_clr;
    logic [7:0]             src, win;
    logic [word_size-1:0]   vector, cause;

    assign rise     = irq_req & ~req_prev;
    assign eligible = pending & irq_mask;
    assign ack_clr  = (state == REQUEST && bus.cpu_ack) ? (num_sources'(1) << src) : '0;

    always_comb begin
        win = '0;
        for (int i = num_sources - 1; i >= 0; i--)
            if (eligible[i]) win = 8'(i);
    end

    always_comb begin
        cause                 = '0;
        cause[word_size-1]    = 1'b1;
        cause[8 +: num_sources] = pending;
        cause[7:0]            = src;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |eligible ? FETCH : IDLE;
            FETCH:   state_nx = CAPTURE;
            CAPTURE: state_nx = LOG;
            LOG:     state_nx = REQUEST;
            REQUEST: state_nx = bus.cpu_ack ? IDLE : REQUEST;
            default: state_nx = IDLE;
        endcase
    end

    // Set wins over the ack clear so an edge coinciding with the ack is not lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pending  <= '0;
            req_prev <= '0;
            src      <= '0;
            vector   <= '0;
        end else begin
            state    <= state_nx;
            req_prev <= irq_req;
            pending  <= (pending & ~ack_clr) | rise;
            if (state == IDLE && |eligible) src <= win;
            if (state == CAPTURE) vector <= bus.ir_rdata;
        end
    end

    assign busy           = state != IDLE;
    assign bus.ir_load    = state == FETCH;
    assign bus.ir_store   = state == LOG;
    assign bus.ir_address = state == FETCH ? reg_address_size'(src)
                          : state == LOG   ? reg_address_size'(cause_address) : '0;
    assign bus.ir_data_in = state == LOG ? cause : '0;
    assign bus.cpu_irq    = state == REQUEST;
    assign bus.cpu_vector = vector;
    assign bus.cpu_source = src;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed checks of interrupt_controller against a small register-file model.
module tb_interrupt_controller;
    localparam logic [31:0] vec_tab [4] = '{32'hA000_0000, 32'h0000_BEEF, 32'h0000_1234, 32'hC0DE_0003};

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] irq_req;
    logic [3:0] irq_mask;
    logic       busy;
    logic [31:0] cause_reg;
    int         n_checks = 0;
    int         n_fail = 0;

    interrupt_controller_if #(.word_size(32), .reg_address_size(5)) bus();

    interrupt_controller #(.word_size(32), .reg_address_size(5), .num_sources(4), .cause_address(4)) dut (
        .clock(clock), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask), .busy(busy), .bus(bus)
    );

    always #5 clock = ~clock;

    // Vector region is read-only; only the cause register is writable.
    always @(posedge clock) begin
        if (bus.ir_store && bus.ir_address == 5'd4) cause_reg <= bus.ir_data_in;
        if (bus.ir_load)
            bus.ir_rdata <= bus.ir_address < 5'd4 ? vec_tab[bus.ir_address[1:0]]
                          : bus.ir_address == 5'd4 ? cause_reg : 32'h0;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_irq(output int cyc);
        cyc = 0;
        while (!bus.cpu_irq && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_ack;
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; irq_req = '0; irq_mask = 4'hF; bus.cpu_ack = 1'b0; cause_reg = '0; bus.ir_rdata = '0;
        repeat (2) tick();
        n_checks++; if ({bus.cpu_irq, busy, bus.ir_load, bus.ir_store} !== 4'b0)
            begin n_fail++; $display("FAIL reset_ctl got %b want 0000", {bus.cpu_irq, busy, bus.ir_load, bus.ir_store}); end
        n_checks++; if ({bus.ir_address, bus.ir_data_in, bus.cpu_vector, bus.cpu_source} !== '0)
            begin n_fail++; $display("FAIL reset_data addr %h data %h vec %h src %h want all 0", bus.ir_address, bus.ir_data_in, bus.cpu_vector, bus.cpu_source); end
        n_checks++; if (dut.pending !== 4'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0000", dut.pending); end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single;
        irq_req = 4'b0100;
        tick();
        irq_req = 4'b0;
        n_checks++; if (dut.pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending got %b want 0100", dut.pending); end
        tick();
        n_checks++; if ({bus.ir_load, bus.ir_store, bus.ir_address} !== {2'b10, 5'd2})
            begin n_fail++; $display("FAIL single_fetch load/store/addr got %b %b %0d want 1 0 2", bus.ir_load, bus.ir_store, bus.ir_address); end
        tick();
        tick();
        n_checks++; if ({bus.ir_load, bus.ir_store, bus.ir_address, bus.ir_data_in} !== {2'b01, 5'd4, 32'h8000_0402})
            begin n_fail++; $display("FAIL single_log load/store/addr/data got %b %b %0d %h want 0 1 4 80000402", bus.ir_load, bus.ir_store, bus.ir_address, bus.ir_data_in); end
        n_checks++; if (bus.cpu_irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_early got %b want 0", bus.cpu_irq); end
        tick();
        n_checks++; if ({bus.cpu_irq, bus.cpu_vector, bus.cpu_source} !== {1'b1, 32'h0000_1234, 8'd2})
            begin n_fail++; $display("FAIL single_request irq %b vec %h src %0d want 1 00001234 2", bus.cpu_irq, bus.cpu_vector, bus.cpu_source); end
        n_checks++; if (cause_reg !== 32'h8000_0402) begin n_fail++; $display("FAIL single_cause got %h want 80000402", cause_reg); end
        do_ack();
        n_checks++; if ({bus.cpu_irq, busy} !== 2'b00) begin n_fail++; $display("FAIL single_ack irq/busy got %b want 00", {bus.cpu_irq, busy}); end
    endtask

    task automatic test_priority;
        int cyc;
        irq_req = 4'b1010;
        tick();
        irq_req = 4'b0;
        wait_irq(cyc);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL prio_latency1 got %0d want 4", cyc); end
        n_checks++; if ({bus.cpu_source, bus.cpu_vector, cause_reg} !== {8'd1, 32'h0000_BEEF, 32'h8000_0A01})
            begin n_fail++; $display("FAIL prio_first src %0d vec %h cause %h want 1 0000beef 80000a01", bus.cpu_source, bus.cpu_vector, cause_reg); end
        do_ack();
        wait_irq(cyc);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL prio_latency2 got %0d want 4", cyc); end
        n_checks++; if ({bus.cpu_source, bus.cpu_vector, cause_reg} !== {8'd3, 32'hC0DE_0003, 32'h8000_0803})
            begin n_fail++; $display("FAIL prio_second src %0d vec %h cause %h want 3 c0de0003 80000803", bus.cpu_source, bus.cpu_vector, cause_reg); end
        do_ack();
    endtask

    task automatic test_mask;
        int cyc;
        int seen = 0;
        irq_mask = 4'b1110;
        irq_req = 4'b0001;
        tick();
        irq_req = 4'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.cpu_irq || busy) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mask_hold active cycles got %0d want 0", seen); end
        n_checks++; if (dut.pending !== 4'b0001) begin n_fail++; $display("FAIL mask_pending got %b want 0001", dut.pending); end
        irq_mask = 4'hF;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mask_unmask busy got %b want 1", busy); end
        wait_irq(cyc);
        n_checks++; if ({bus.cpu_source, bus.cpu_vector, cause_reg} !== {8'd0, 32'hA000_0000, 32'h8000_0100})
            begin n_fail++; $display("FAIL mask_service src %0d vec %h cause %h want 0 a0000000 80000100", bus.cpu_source, bus.cpu_vector, cause_reg); end
        do_ack();
    endtask

    task automatic test_set_wins;
        int cyc;
        irq_req = 4'b1000;
        tick();
        irq_req = 4'b0;
        wait_irq(cyc);
        irq_req = 4'b1000;
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        irq_req = 4'b0;
        n_checks++; if ({bus.cpu_irq, dut.pending} !== 5'b0_1000)
            begin n_fail++; $display("FAIL setwins_pending irq %b pending %b want 0 1000", bus.cpu_irq, dut.pending); end
        wait_irq(cyc);
        n_checks++; if ({cyc[7:0], bus.cpu_source} !== {8'd4, 8'd3})
            begin n_fail++; $display("FAIL setwins_again latency %0d src %0d want 4 3", cyc, bus.cpu_source); end
        do_ack();
    endtask

    task automatic test_async_reset;
        int cyc;
        int seen = 0;
        irq_req = 4'b0010;
        tick();
        irq_req = 4'b0;
        wait_irq(cyc);
        n_checks++; if (bus.cpu_irq !== 1'b1) begin n_fail++; $display("FAIL areset_reach irq got %b want 1", bus.cpu_irq); end
        irq_req = 4'b0100;
        tick();
        irq_req = 4'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({bus.cpu_irq, busy, dut.pending} !== 6'b0)
            begin n_fail++; $display("FAIL areset_immediate irq %b busy %b pending %b want 0 0 0000", bus.cpu_irq, busy, dut.pending); end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy || bus.cpu_irq) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL areset_idle active cycles got %0d want 0", seen); end
        irq_req = 4'b0001;
        tick();
        irq_req = 4'b0;
        wait_irq(cyc);
        n_checks++; if ({cyc[7:0], bus.cpu_source} !== {8'd4, 8'd0})
            begin n_fail++; $display("FAIL areset_resume latency %0d src %0d want 4 0", cyc, bus.cpu_source); end
        do_ack();
    endtask

    task automatic test_random;
        int cyc = 0;
        for (int k = 0; k < 10000; k++) begin
            irq_req = 4'($urandom);
            irq_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            bus.cpu_ack = ($urandom_range(0, 2) == 0);
            tick();
            n_checks++; if ((bus.ir_load & bus.ir_store) !== 1'b0)
                begin n_fail++; $display("FAIL rand_strobe cycle %0d load&store got 1 want 0", k); end
            if (bus.cpu_irq) begin
                n_checks++; if (bus.cpu_source > 8'd3 || bus.cpu_vector !== vec_tab[bus.cpu_source[1:0]])
                    begin n_fail++; $display("FAIL rand_vector cycle %0d src %0d vec %h", k, bus.cpu_source, bus.cpu_vector); end
            end
        end
        irq_req = 4'b0;
        irq_mask = 4'hF;
        bus.cpu_ack = 1'b1;
        while ((busy || dut.pending != 4'b0) && cyc < 200) begin
            tick();
            cyc++;
        end
        bus.cpu_ack = 1'b0;
        tick();
        n_checks++; if ({busy, dut.pending} !== 5'b0) begin n_fail++; $display("FAIL rand_drain busy %b pending %b want 0 0000", busy, dut.pending); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_set_wins();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
